// File: rtl/williams2_video_out.sv
// Video output stage: pixel-enable divider, sync-relative blanking, intensity colour expansion.
// Optional dark palette selected by defining WILLIAMS2_DARK_MODE_EN.
module williams2_video_out #(
  parameter int unsigned H_START  = 48,
  parameter int unsigned H_ACTIVE = 292,
  parameter int unsigned V_START  = 16,
  parameter int unsigned V_ACTIVE = 240
) (
  input  logic       i_clock_12,
  input  logic       i_reset,
  input  logic [3:0] i_vid_r,
  input  logic [3:0] i_vid_g,
  input  logic [3:0] i_vid_b,
  input  logic [3:0] i_vid_i,
  input  logic       i_vid_hs,
  input  logic       i_vid_vs,
`ifdef WILLIAMS2_DARK_MODE_EN
  input  logic       i_dark_mode,
`endif
  output logic       o_ce_pix,
  output logic [7:0] o_out_r,
  output logic [7:0] o_out_g,
  output logic [7:0] o_out_b,
  output logic       o_out_hs,
  output logic       o_out_vs,
  output logic       o_out_hblank,
  output logic       o_out_vblank,
  output logic       o_out_de
);

  // Window bounds widened to 10 bits so the exclusive end may exceed the 9-bit counter range.
  localparam logic [9:0] L_H_FIRST = 10'(H_START);
  localparam logic [9:0] L_H_END   = 10'(H_START + H_ACTIVE);
  localparam logic [9:0] L_V_FIRST = 10'(V_START);
  localparam logic [9:0] L_V_END   = 10'(V_START + V_ACTIVE);

  logic       r_div;
  logic       w_ce;

  logic [3:0] r_s1_r;
  logic [3:0] r_s1_g;
  logic [3:0] r_s1_b;
  logic [3:0] r_s1_i;
  logic       r_s1_hs;
  logic       r_s1_vs;
  logic [8:0] r_hcnt;
  logic [8:0] r_vcnt;

  logic       w_hs_rise;
  logic       w_vs_rise;
  logic [8:0] w_hcnt_d;
  logic [8:0] w_vcnt_d;
  logic       w_s1_hblank;
  logic       w_s1_vblank;
  logic       w_dark;

  logic [7:0] w_s2_r;
  logic [7:0] w_s2_g;
  logic [7:0] w_s2_b;

  logic [7:0] r_out_r;
  logic [7:0] r_out_g;
  logic [7:0] r_out_b;
  logic       r_out_hs;
  logic       r_out_vs;
  logic       r_out_hblank;
  logic       r_out_vblank;

  // Colour expansion: bright adds the top nibble of the product back in (max 225+14=239).
  function automatic logic [7:0] f_expand(input logic [3:0] c, input logic [3:0] i,
                                          input logic dark);
    logic [7:0] prod;
    prod = {4'd0, c} * {4'd0, i};
    if (dark) begin
      return prod;
    end
    return prod + {4'd0, prod[7:4]};
  endfunction

`ifdef WILLIAMS2_DARK_MODE_EN
  assign w_dark = i_dark_mode;
`else
  assign w_dark = 1'b0;
`endif

  always_ff @(posedge i_clock_12 or posedge i_reset) begin
    if (i_reset) begin
      r_div <= 1'b0;
    end else begin
      r_div <= ~r_div;
    end
  end

  assign w_ce = r_div;

  assign w_hs_rise = i_vid_hs & ~r_s1_hs;
  assign w_vs_rise = i_vid_vs & ~r_s1_vs;

  // Counters saturate so a lost sync parks them outside the active window.
  always_comb begin
    w_hcnt_d = r_hcnt;
    w_vcnt_d = r_vcnt;
    if (w_hs_rise) begin
      w_hcnt_d = 9'd0;
    end else if (r_hcnt != 9'h1FF) begin
      w_hcnt_d = r_hcnt + 9'd1;
    end
    if (w_vs_rise) begin
      w_vcnt_d = 9'd0;
    end else if (w_hs_rise && (r_vcnt != 9'h1FF)) begin
      w_vcnt_d = r_vcnt + 9'd1;
    end
  end

  always_ff @(posedge i_clock_12 or posedge i_reset) begin
    if (i_reset) begin
      r_s1_r  <= 4'd0;
      r_s1_g  <= 4'd0;
      r_s1_b  <= 4'd0;
      r_s1_i  <= 4'd0;
      r_s1_hs <= 1'b0;
      r_s1_vs <= 1'b0;
      r_hcnt  <= 9'd0;
      r_vcnt  <= 9'd0;
    end else if (w_ce) begin
      r_s1_r  <= i_vid_r;
      r_s1_g  <= i_vid_g;
      r_s1_b  <= i_vid_b;
      r_s1_i  <= i_vid_i;
      r_s1_hs <= i_vid_hs;
      r_s1_vs <= i_vid_vs;
      r_hcnt  <= w_hcnt_d;
      r_vcnt  <= w_vcnt_d;
    end
  end

  always_comb begin
    w_s1_hblank = !(({1'b0, r_hcnt} >= L_H_FIRST) && ({1'b0, r_hcnt} < L_H_END));
    w_s1_vblank = !(({1'b0, r_vcnt} >= L_V_FIRST) && ({1'b0, r_vcnt} < L_V_END));
  end

  always_comb begin
    w_s2_r = 8'd0;
    w_s2_g = 8'd0;
    w_s2_b = 8'd0;
    if (!(w_s1_hblank || w_s1_vblank)) begin
      w_s2_r = f_expand(r_s1_r, r_s1_i, w_dark);
      w_s2_g = f_expand(r_s1_g, r_s1_i, w_dark);
      w_s2_b = f_expand(r_s1_b, r_s1_i, w_dark);
    end
  end

  always_ff @(posedge i_clock_12 or posedge i_reset) begin
    if (i_reset) begin
      r_out_r      <= 8'd0;
      r_out_g      <= 8'd0;
      r_out_b      <= 8'd0;
      r_out_hs     <= 1'b0;
      r_out_vs     <= 1'b0;
      r_out_hblank <= 1'b1;
      r_out_vblank <= 1'b1;
    end else if (w_ce) begin
      r_out_r      <= w_s2_r;
      r_out_g      <= w_s2_g;
      r_out_b      <= w_s2_b;
      r_out_hs     <= r_s1_hs;
      r_out_vs     <= r_s1_vs;
      r_out_hblank <= w_s1_hblank;
      r_out_vblank <= w_s1_vblank;
    end
  end

  assign o_ce_pix     = w_ce;
  assign o_out_r      = r_out_r;
  assign o_out_g      = r_out_g;
  assign o_out_b      = r_out_b;
  assign o_out_hs     = r_out_hs;
  assign o_out_vs     = r_out_vs;
  assign o_out_hblank = r_out_hblank;
  assign o_out_vblank = r_out_vblank;
  assign o_out_de     = ~(r_out_hblank | r_out_vblank);

endmodule

// File: tb/tb_williams2_video_out.sv
// Self-checking bench for williams2_video_out: colour vector table plus directed timing sequences.
module tb_williams2_video_out;

  typedef struct {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [3:0] i;
    logic       dark;
    logic [7:0] br;
    logic [7:0] bg;
    logic [7:0] bb;
    logic [7:0] dr;
    logic [7:0] dg;
    logic [7:0] db;
  } vec_t;

`ifdef WILLIAMS2_DARK_MODE_EN
  localparam bit DarkEn = 1'b1;
  logic dark_mode = 1'b0;
`else
  localparam bit DarkEn = 1'b0;
`endif
  localparam int NumVec = 10;
  localparam int TblBase = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] vid_r = 4'd0;
  logic [3:0] vid_g = 4'd0;
  logic [3:0] vid_b = 4'd0;
  logic [3:0] vid_i = 4'd0;
  logic       vid_hs = 1'b0;
  logic       vid_vs = 1'b0;
  logic       ce_pix;
  logic [7:0] out_r;
  logic [7:0] out_g;
  logic [7:0] out_b;
  logic       out_hs;
  logic       out_vs;
  logic       out_hblank;
  logic       out_vblank;
  logic       out_de;

  int checks = 0;
  int errors = 0;
  vec_t tbl[NumVec];

  williams2_video_out dut (
    .i_clock_12  (clk),
    .i_reset     (rst),
    .i_vid_r     (vid_r),
    .i_vid_g     (vid_g),
    .i_vid_b     (vid_b),
    .i_vid_i     (vid_i),
    .i_vid_hs    (vid_hs),
    .i_vid_vs    (vid_vs),
`ifdef WILLIAMS2_DARK_MODE_EN
    .i_dark_mode (dark_mode),
`endif
    .o_ce_pix    (ce_pix),
    .o_out_r     (out_r),
    .o_out_g     (out_g),
    .o_out_b     (out_b),
    .o_out_hs    (out_hs),
    .o_out_vs    (out_vs),
    .o_out_hblank(out_hblank),
    .o_out_vblank(out_vblank),
    .o_out_de    (out_de)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_r"}, 32'(out_r), 32'd0);
    chk({tag, "_g"}, 32'(out_g), 32'd0);
    chk({tag, "_b"}, 32'(out_b), 32'd0);
    chk({tag, "_hs"}, 32'(out_hs), 32'd0);
    chk({tag, "_vs"}, 32'(out_vs), 32'd0);
    chk({tag, "_hblank"}, 32'(out_hblank), 32'd1);
    chk({tag, "_vblank"}, 32'(out_vblank), 32'd1);
    chk({tag, "_de"}, 32'(out_de), 32'd0);
  endtask

  // Advance to just after the next clock edge on which ce_pix is high.
  task automatic tick();
    int n;
    n = 0;
    @(negedge clk);
    while ((ce_pix !== 1'b1) && (n < 4)) begin
      @(negedge clk);
      n++;
    end
    if (ce_pix !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL ce_timeout actual=%0d required=1", ce_pix);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b,
                       input logic [3:0] i, input logic hs, input logic vs);
    vid_r  = r;
    vid_g  = g;
    vid_b  = b;
    vid_i  = i;
    vid_hs = hs;
    vid_vs = vs;
    tick();
  endtask

  initial begin
    int p;
    int glitch;
    int both_hi;
    logic prev_ce;
    logic exp_blank;
    logic exp_vb;
    logic use_dark;
    logic [3:0] cr;
    logic [3:0] cg;
    logic [3:0] cb;
    logic [3:0] ci;

    //              r     g     b     i     dk    bright r,g,b        dark r,g,b
    tbl[0] = '{4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 8'd239, 8'd239, 8'd239, 8'd225, 8'd225, 8'd225};
    tbl[1] = '{4'h3, 4'h3, 4'h3, 4'h5, 1'b1, 8'd15,  8'd15,  8'd15,  8'd15,  8'd15,  8'd15};
    tbl[2] = '{4'h0, 4'h0, 4'h0, 4'hF, 1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    tbl[3] = '{4'hF, 4'h0, 4'h8, 4'h8, 1'b1, 8'd127, 8'd0,   8'd68,  8'd120, 8'd0,   8'd64};
    tbl[4] = '{4'h1, 4'h2, 4'h4, 4'h1, 1'b0, 8'd1,   8'd2,   8'd4,   8'd1,   8'd2,   8'd4};
    tbl[5] = '{4'hA, 4'h5, 4'hC, 4'hA, 1'b1, 8'd106, 8'd53,  8'd127, 8'd100, 8'd50,  8'd120};
    tbl[6] = '{4'h7, 4'h9, 4'hE, 4'h0, 1'b0, 8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0};
    tbl[7] = '{4'hF, 4'hF, 4'hF, 4'h1, 1'b1, 8'd15,  8'd15,  8'd15,  8'd15,  8'd15,  8'd15};
    tbl[8] = '{4'h4, 4'h4, 4'h4, 4'h4, 1'b0, 8'd17,  8'd17,  8'd17,  8'd16,  8'd16,  8'd16};
    tbl[9] = '{4'hB, 4'hD, 4'h6, 4'h7, 1'b1, 8'd81,  8'd96,  8'd44,  8'd77,  8'd91,  8'd42};

    // Reset state and divider cadence.
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ce", 32'(ce_pix), 32'd0);
    chk_reset_vals("rst");
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ce", 32'(ce_pix), 32'd0);
    chk_reset_vals("rel");
    prev_ce = 1'b0;
    both_hi = 0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      chk("ce_pattern", 32'(ce_pix), 32'(n % 2));
      if (prev_ce && ce_pix) both_hi++;
      prev_ce = ce_pix;
    end
    chk("ce_no_consecutive", 32'(both_hi), 32'd0);

    // Vertical blanking: hs and vs rise together, then 2-ce lines.
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    for (int v = 1; v <= 257; v++) begin
      drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      if (v == 1) begin
        chk("sync_hs_delayed", 32'(out_hs), 32'd1);
        chk("sync_vs_delayed", 32'(out_vs), 32'd1);
      end
      p = v - 1;
      if (p == 0 || p == 15 || p == 16 || p == 255 || p == 256) begin
        exp_vb = (p < 16) || (p >= 256);
        chk($sformatf("vblank_line%0d", p), 32'(out_vblank), 32'(exp_vb));
        chk($sformatf("vline_de%0d", p), 32'(out_de), 32'd0);
      end
      drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    end
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    chk("hs_dropped", 32'(out_hs), 32'd1);

    // New frame, advance to line 16, then sweep one line with colour vectors inside.
    drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      drive(4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    end
    for (int h = 1; h <= 345; h++) begin
      p = h - 1;
      cr = 4'hF;
      cg = 4'hF;
      cb = 4'hF;
      ci = 4'hF;
      if (h >= TblBase && h < TblBase + NumVec) begin
        cr = tbl[h - TblBase].r;
        cg = tbl[h - TblBase].g;
        cb = tbl[h - TblBase].b;
        ci = tbl[h - TblBase].i;
      end
`ifdef WILLIAMS2_DARK_MODE_EN
      // Palette select is taken while the pixel sits in stage 1, i.e. on the following ce.
      dark_mode = (p >= TblBase && p < TblBase + NumVec) ? tbl[p - TblBase].dark : 1'b0;
`endif
      drive(cr, cg, cb, ci, 1'b0, 1'b0);
      if (p == 47 || p == 48 || p == 339 || p == 340) begin
        exp_blank = (p < 48) || (p >= 340);
        chk($sformatf("hblank_px%0d", p), 32'(out_hblank), 32'(exp_blank));
        chk($sformatf("de_px%0d", p), 32'(out_de), 32'(!exp_blank));
        chk($sformatf("r_px%0d", p), 32'(out_r), exp_blank ? 32'd0 : 32'd239);
      end
      if (p >= TblBase && p < TblBase + NumVec) begin
        use_dark = DarkEn && tbl[p - TblBase].dark;
        chk($sformatf("vec%0d_r", p - TblBase), 32'(out_r),
            32'(use_dark ? tbl[p - TblBase].dr : tbl[p - TblBase].br));
        chk($sformatf("vec%0d_g", p - TblBase), 32'(out_g),
            32'(use_dark ? tbl[p - TblBase].dg : tbl[p - TblBase].bg));
        chk($sformatf("vec%0d_b", p - TblBase), 32'(out_b),
            32'(use_dark ? tbl[p - TblBase].db : tbl[p - TblBase].bb));
      end
    end
`ifdef WILLIAMS2_DARK_MODE_EN
    dark_mode = 1'b0;
`endif

    // Missing hsync: counter must saturate, never wrapping back into the window.
    glitch = 0;
    for (int k = 0; k < 600; k++) begin
      drive(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
      if (out_hblank !== 1'b1 || out_de !== 1'b0 || out_r !== 8'd0) glitch++;
    end
    chk("hsat_glitches", 32'(glitch), 32'd0);
    chk("hsat_hblank", 32'(out_hblank), 32'd1);

    // Fresh hs on line 16, run into the active area, then reset asynchronously mid-line.
    drive(4'hF, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
    for (int k = 0; k < 60; k++) begin
      drive(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
    end
    chk("pre_reset_de", 32'(out_de), 32'd1);
    chk("pre_reset_r", 32'(out_r), 32'd239);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_ce", 32'(ce_pix), 32'd0);
    chk_reset_vals("midrst");
    @(negedge clk);
    rst = 1'b0;
    glitch = 0;
    for (int k = 0; k < 100; k++) begin
      drive(4'hF, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0);
      if (out_de !== 1'b0 || out_r !== 8'd0) glitch++;
    end
    chk("post_reset_no_active", 32'(glitch), 32'd0);
    chk("post_reset_vblank", 32'(out_vblank), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
